inst_fetch_bridge: RTL and testbench
====================================

// Module: inst_fetch_bridge
// PURPOSE
//  Responder end of the PC-request interface: accepts pc/ce from the PC register and fetches the word from
//  instruction memory over a req/addr_ok/data_ok SRAM-like bus. Returns the instruction to IF/ID and a
//  one-cycle pc_read_ready that lets the PC register advance. At most one outstanding read.
//  Absorbs stall, and drops responses that a flush makes stale.
// PARAMETERS
//  ADDR_W   32        width of pc and inst_addr
//  DATA_W   32        instruction word width
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       asynchronous, active-low reset (0 = reset asserted)
//  pc             in   ADDR_W  fetch address from PC register
//  ce             in   1       PC register chip enable; 0 = no fetch
//  stall          in   1       CTRL stall for the IF stage
//  flush          in   1       CTRL exception flush; pc carries new_pc from the next cycle
//  inst_req       out  1       read request to instruction memory
//  inst_addr      out  ADDR_W  word-aligned request address {pc[ADDR_W-1:2],2'b00}
//  inst_addr_ok   in   1       memory accepted request (handshake with inst_req)
//  inst_data_ok   in   1       read data valid, one cycle
//  inst_rdata     in   DATA_W  read data
//  pc_read_ready  out  1       1-cycle pulse: instruction delivered; PC register may advance
//  if_inst        out  DATA_W  instruction to IF/ID; valid only while pc_read_ready=1
//  if_pc          out  ADDR_W  address of if_inst
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; inst_req=0, inst_addr=0, pc_read_ready=0, if_inst=0, if_pc=0,
//   hold buffer=0.
//  States: IDLE, REQ, WAIT, HOLD, DROP. The state, inst_req and inst_addr are registered.
//   pc_read_ready, if_inst and if_pc are combinational from the state and the inputs.
//  IDLE: if ce=1 & flush=0 & stall=0, go to REQ and latch inst_addr/if_pc from pc. Otherwise stay.
//   inst_data_ok in IDLE is ignored.
//  REQ: inst_req=1, and inst_addr is held stable until inst_addr_ok. A request is never withdrawn.
//   On inst_addr_ok go to WAIT, or to DROP if flush arrived in this REQ (flush is latched in drop_pend).
//  WAIT: on inst_data_ok:
//   flush=0 & stall=0: pc_read_ready=1, if_inst=inst_rdata; next state IDLE.
//   flush=0 & stall=1: capture inst_rdata into the hold buffer; go to HOLD.
//   flush=1: discard the data; go to IDLE.
//   flush without data_ok: go to DROP.
//  HOLD: flush=1 -> IDLE, no pulse. stall=0 -> pc_read_ready=1, if_inst=hold buffer; go to IDLE.
//  DROP: wait for inst_data_ok, discard it, go to IDLE. pc_read_ready is never asserted in DROP.
//  pc_read_ready is never 1 in a cycle with flush=1. It is at most one pulse per request.
//  Latency with no stall: pc stable in IDLE -> req next cycle -> pulse in the inst_data_ok cycle.
//   With zero-wait memory (addr_ok same cycle, data_ok next cycle) that is 3 cycles per instruction.
//  The PC register updates pc on the edge that ends the pulse. IDLE samples the new pc on the
//   following cycle, so no stale address is ever requested.
//  ce falling mid-transaction: the transaction completes, and the data is delivered/dropped as above.
//   No new request until ce=1.
//  flush and inst_data_ok in the same cycle: flush wins, and the data is dropped.
//  flush and inst_addr_ok in the same REQ cycle: go to DROP.
//  Reset mid-transaction: the FSM aborts to IDLE. Memory is reset by the same rst, so no late
//   data_ok is expected. Any late data_ok arrives in IDLE and is ignored.
// STRUCTURE
//  defines.v gains:
//   IF_IDLE/IF_REQ/IF_WAIT/IF_HOLD/IF_DROP 3-bit state encodings.
//   Reuse of `Ready, `ZeroWord, `RegBus, `InstBus.
//  Single module; the FSM, the address/hold registers and the drop_pend flag are inline.
//  No sub-module is warranted.
// TESTING
//  1 Zero-wait: pc=bfc00000, ce=1, addr_ok same cycle, data_ok+1 with 3c000001 -> pulse=1 one cycle,
//    if_inst=3c000001, if_pc=bfc00000; next req addr=bfc00004.
//  2 Slow memory: addr_ok delayed 3 cycles -> inst_req/inst_addr stable all 3 cycles, single pulse only.
//  3 Stall: stall=1 when data_ok brings 24020005 -> no pulse; after stall falls 5 cycles later,
//    pulse=1 with if_inst=24020005; no second memory request meanwhile.
//  4 Flush in WAIT: flush=1 before data_ok -> DROP; the data_ok word is discarded with no pulse;
//    next req uses new_pc=bfc00380.
//  5 Flush colliding with data_ok, and flush with addr_ok -> no pulse in either case; exactly one
//    following request to bfc00380.
//  6 Async reset asserted in WAIT -> outputs zero immediately; after release with ce=1,
//    req to bfc00000 and late data_ok ignored.

Source files
------------

// File: rtl/inst_fetch_bridge_pkg.sv
// Shared types for the instruction-fetch bridge.
// Holds the fetch FSM state encoding.
package inst_fetch_bridge_pkg;

    localparam int IF_STATE_W = 3;

    typedef enum logic [IF_STATE_W-1:0] {
        IF_IDLE = 3'd0,
        IF_REQ  = 3'd1,
        IF_WAIT = 3'd2,
        IF_HOLD = 3'd3,
        IF_DROP = 3'd4
    } if_state_e;

endpackage

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: PC request in, SRAM-like req/addr_ok/data_ok out.
// Ports: clk, rst (async active-low), pc/ce/stall/flush from PC+CTRL,
//   inst_req/inst_addr/inst_addr_ok/inst_data_ok/inst_rdata to imem,
//   pc_read_ready/if_inst/if_pc to PC register and IF/ID.
module inst_fetch_bridge
    import inst_fetch_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              ce,
    input  logic              stall,
    input  logic              flush,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_rdata,
    output logic              pc_read_ready,
    output logic [DATA_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc
);

    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(3);

    if_state_e         state;
    if_state_e         state_n;
    logic [DATA_W-1:0] hold_buf;
    logic [ADDR_W-1:0] pc_q;
    logic              drop_pend;
    logic              launch;
    logic              capture;
    logic              set_drop;

    always_comb begin
        state_n       = state;
        pc_read_ready = 1'b0;
        if_inst       = '0;
        launch        = 1'b0;
        capture       = 1'b0;
        set_drop      = 1'b0;
        unique case (state)
            IF_IDLE: begin
                if (ce && !flush && !stall) begin
                    state_n = IF_REQ;
                    launch  = 1'b1;
                end
            end
            IF_REQ: begin
                // A flush seen before acceptance must still drop the reply.
                if (inst_addr_ok) begin
                    state_n = (flush || drop_pend) ? IF_DROP : IF_WAIT;
                end else if (flush) begin
                    set_drop = 1'b1;
                end
            end
            IF_WAIT: begin
                if (inst_data_ok) begin
                    if (flush) begin
                        state_n = IF_IDLE;
                    end else if (stall) begin
                        state_n = IF_HOLD;
                        capture = 1'b1;
                    end else begin
                        state_n       = IF_IDLE;
                        pc_read_ready = 1'b1;
                        if_inst       = inst_rdata;
                    end
                end else if (flush) begin
                    state_n = IF_DROP;
                end
            end
            IF_HOLD: begin
                if (flush) begin
                    state_n = IF_IDLE;
                end else if (!stall) begin
                    state_n       = IF_IDLE;
                    pc_read_ready = 1'b1;
                    if_inst       = hold_buf;
                end
            end
            IF_DROP: begin
                if (inst_data_ok) begin
                    state_n = IF_IDLE;
                end
            end
            default: begin
                state_n = IF_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IF_IDLE;
            inst_req  <= 1'b0;
            inst_addr <= '0;
            pc_q      <= '0;
            hold_buf  <= '0;
            drop_pend <= 1'b0;
        end else begin
            state    <= state_n;
            inst_req <= (state_n == IF_REQ);
            if (launch) begin
                inst_addr <= pc & ~LOW_MASK;
                pc_q      <= pc;
            end
            if (capture) begin
                hold_buf <= inst_rdata;
            end
            if (state_n != IF_REQ) begin
                drop_pend <= 1'b0;
            end else if (set_drop) begin
                drop_pend <= 1'b1;
            end
        end
    end

    assign if_pc = pc_q;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed self-checking bench for inst_fetch_bridge.
// Each task drives one scenario and checks outputs 3ns after the edge.
module tb_inst_fetch_bridge;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        ce;
    logic        stall;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        pc_read_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;

    int checks;
    int failures;

    inst_fetch_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .ce           (ce),
        .stall        (stall),
        .flush        (flush),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .pc_read_ready(pc_read_ready),
        .if_inst      (if_inst),
        .if_pc        (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 2ns after the rising edge; checks follow 1ns later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        ce           = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pc  = 32'hbfc00000;
        idle_inputs();
        tick();
        tick();
        settle();
        checks++;
        if (inst_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_req got=%b exp=0", inst_req);
        end
        checks++;
        if (inst_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=0", inst_addr);
        end
        checks++;
        if (pc_read_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=0", pc_read_ready);
        end
        checks++;
        if (if_inst !== 32'h0 || if_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_if got=%h/%h exp=0/0", if_inst, if_pc);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_zero_wait();
        pc = 32'hbfc00000;
        ce = 1'b1;
        tick();
        settle();
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00000) begin
            failures++;
            $display("FAIL zw_req got=%b/%h exp=1/bfc00000", inst_req, inst_addr);
        end
        inst_addr_ok = 1'b1;
        settle();
        checks++;
        if (pc_read_ready !== 1'b0) begin
            failures++;
            $display("FAIL zw_early_ready got=%b exp=0", pc_read_ready);
        end
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h3c000001;
        settle();
        checks++;
        if (pc_read_ready !== 1'b1 || if_inst !== 32'h3c000001 ||
            if_pc !== 32'hbfc00000) begin
            failures++;
            $display("FAIL zw_deliver got=%b/%h/%h exp=1/3c000001/bfc00000",
                     pc_read_ready, if_inst, if_pc);
        end
        tick();
        inst_data_ok = 1'b0;
        pc = 32'hbfc00004;
        settle();
        checks++;
        if (pc_read_ready !== 1'b0 || inst_req !== 1'b0) begin
            failures++;
            $display("FAIL zw_one_pulse got=%b/%b exp=0/0", pc_read_ready, inst_req);
        end
        tick();
        settle();
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00004) begin
            failures++;
            $display("FAIL zw_next_req got=%b/%h exp=1/bfc00004", inst_req, inst_addr);
        end
        // ce drops mid-transaction: the fetch still completes.
        ce = 1'b0;
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h00000000;
        settle();
        checks++;
        if (pc_read_ready !== 1'b1 || if_pc !== 32'hbfc00004) begin
            failures++;
            $display("FAIL zw_ce_drop got=%b/%h exp=1/bfc00004", pc_read_ready, if_pc);
        end
        tick();
        inst_data_ok = 1'b0;
        tick();
        settle();
        checks++;
        if (inst_req !== 1'b0) begin
            failures++;
            $display("FAIL zw_no_ce_req got=%b exp=0", inst_req);
        end
    endtask

    task automatic test_slow_mem();
        int pulses;
        pc = 32'hbfc00008;
        ce = 1'b1;
        tick();
        ce = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00008 ||
                pc_read_ready !== 1'b0) begin
                failures++;
                $display("FAIL slow_hold_%0d got=%b/%h/%b exp=1/bfc00008/0",
                         i, inst_req, inst_addr, pc_read_ready);
            end
            tick();
        end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h11112222;
        settle();
        if (pc_read_ready === 1'b1) pulses++;
        checks++;
        if (if_inst !== 32'h11112222) begin
            failures++;
            $display("FAIL slow_data got=%h exp=11112222", if_inst);
        end
        tick();
        inst_data_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            if (pc_read_ready === 1'b1) pulses++;
            tick();
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL slow_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_stall();
        int reqs;
        pc = 32'hbfc00010;
        ce = 1'b1;
        tick();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        stall        = 1'b1;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h24020005;
        settle();
        checks++;
        if (pc_read_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_no_pulse got=%b exp=0", pc_read_ready);
        end
        tick();
        inst_data_ok = 1'b0;
        inst_rdata   = 32'hdeadbeef;
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            if (inst_req === 1'b1) reqs++;
            checks++;
            if (pc_read_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold_%0d got=%b exp=0", i, pc_read_ready);
            end
            if (i < 4) tick();
        end
        checks++;
        if (reqs !== 0) begin
            failures++;
            $display("FAIL stall_extra_req got=%0d exp=0", reqs);
        end
        tick();
        stall = 1'b0;
        settle();
        checks++;
        if (pc_read_ready !== 1'b1 || if_inst !== 32'h24020005 ||
            if_pc !== 32'hbfc00010) begin
            failures++;
            $display("FAIL stall_release got=%b/%h/%h exp=1/24020005/bfc00010",
                     pc_read_ready, if_inst, if_pc);
        end
        ce = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_flush_wait();
        pc = 32'hbfc00020;
        ce = 1'b1;
        tick();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        flush = 1'b1;
        settle();
        checks++;
        if (pc_read_ready !== 1'b0) begin
            failures++;
            $display("FAIL fw_flush_ready got=%b exp=0", pc_read_ready);
        end
        tick();
        flush = 1'b0;
        pc = 32'hbfc00380;
        settle();
        checks++;
        if (inst_req !== 1'b0) begin
            failures++;
            $display("FAIL fw_drop_req got=%b exp=0", inst_req);
        end
        tick();
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h0badf00d;
        settle();
        checks++;
        if (pc_read_ready !== 1'b0 || inst_req !== 1'b0) begin
            failures++;
            $display("FAIL fw_drop_data got=%b/%b exp=0/0", pc_read_ready, inst_req);
        end
        tick();
        inst_data_ok = 1'b0;
        tick();
        settle();
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00380) begin
            failures++;
            $display("FAIL fw_new_pc got=%b/%h exp=1/bfc00380", inst_req, inst_addr);
        end
        ce = 1'b0;
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h12345678;
        settle();
        checks++;
        if (pc_read_ready !== 1'b1 || if_pc !== 32'hbfc00380) begin
            failures++;
            $display("FAIL fw_new_deliver got=%b/%h exp=1/bfc00380", pc_read_ready, if_pc);
        end
        tick();
        inst_data_ok = 1'b0;
        tick();
    endtask

    task automatic test_flush_collide();
        int reqs;
        pc = 32'hbfc00040;
        ce = 1'b1;
        tick();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'haaaa5555;
        flush        = 1'b1;
        settle();
        checks++;
        if (pc_read_ready !== 1'b0) begin
            failures++;
            $display("FAIL fc_data_flush got=%b exp=0", pc_read_ready);
        end
        tick();
        inst_data_ok = 1'b0;
        flush = 1'b0;
        pc = 32'hbfc00380;
        tick();
        settle();
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00380) begin
            failures++;
            $display("FAIL fc_req_380 got=%b/%h exp=1/bfc00380", inst_req, inst_addr);
        end
        inst_addr_ok = 1'b1;
        flush = 1'b1;
        settle();
        checks++;
        if (pc_read_ready !== 1'b0) begin
            failures++;
            $display("FAIL fc_addr_flush got=%b exp=0", pc_read_ready);
        end
        tick();
        inst_addr_ok = 1'b0;
        flush = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h55550000;
        settle();
        checks++;
        if (pc_read_ready !== 1'b0 || inst_req !== 1'b0) begin
            failures++;
            $display("FAIL fc_drop got=%b/%b exp=0/0", pc_read_ready, inst_req);
        end
        tick();
        inst_data_ok = 1'b0;
        tick();
        settle();
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00380) begin
            failures++;
            $display("FAIL fc_refetch got=%b/%h exp=1/bfc00380", inst_req, inst_addr);
        end
        // Flush in REQ before acceptance: the late reply must still be dropped.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h77778888;
        settle();
        checks++;
        if (pc_read_ready !== 1'b0) begin
            failures++;
            $display("FAIL fc_pend_drop got=%b exp=0", pc_read_ready);
        end
        tick();
        inst_data_ok = 1'b0;
        tick();
        settle();
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00380) begin
            failures++;
            $display("FAIL fc_pend_refetch got=%b/%h exp=1/bfc00380", inst_req, inst_addr);
        end
        ce = 1'b0;
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h99990001;
        settle();
        checks++;
        if (pc_read_ready !== 1'b1 || if_inst !== 32'h99990001) begin
            failures++;
            $display("FAIL fc_final got=%b/%h exp=1/99990001", pc_read_ready, if_inst);
        end
        tick();
        inst_data_ok = 1'b0;
        reqs = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            if (inst_req === 1'b1) reqs++;
            tick();
        end
        checks++;
        if (reqs !== 0) begin
            failures++;
            $display("FAIL fc_extra_req got=%0d exp=0", reqs);
        end
    endtask

    task automatic test_reset_mid();
        pc = 32'hbfc00100;
        ce = 1'b1;
        tick();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        rst = 1'b0;
        settle();
        checks++;
        if (inst_req !== 1'b0 || inst_addr !== 32'h0 || if_pc !== 32'h0 ||
            pc_read_ready !== 1'b0) begin
            failures++;
            $display("FAIL rm_async got=%b/%h/%h/%b exp=0/0/0/0",
                     inst_req, inst_addr, if_pc, pc_read_ready);
        end
        tick();
        pc = 32'hbfc00000;
        rst = 1'b1;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hfeedface;
        settle();
        checks++;
        if (pc_read_ready !== 1'b0) begin
            failures++;
            $display("FAIL rm_late_data got=%b exp=0", pc_read_ready);
        end
        tick();
        inst_data_ok = 1'b0;
        settle();
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00000) begin
            failures++;
            $display("FAIL rm_restart got=%b/%h exp=1/bfc00000", inst_req, inst_addr);
        end
        ce = 1'b0;
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h3c000001;
        settle();
        checks++;
        if (pc_read_ready !== 1'b1 || if_inst !== 32'h3c000001) begin
            failures++;
            $display("FAIL rm_deliver got=%b/%h exp=1/3c000001", pc_read_ready, if_inst);
        end
        tick();
        inst_data_ok = 1'b0;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_zero_wait();
        test_slow_mem();
        test_stall();
        test_flush_wait();
        test_flush_collide();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
